// File: rtl/prefix_sum_stage_pkg.sv
// prefix_sum_stage_pkg: shared constants for the prefix-sum output stage.
//   INPUTSIZE_DEF/GROUPSIZE_DEF : default operand width and group size
//   GP_P/GP_G                   : bit positions of P and G within a tree (G,P) pair
//   RES_*                       : field offsets inside the packed result word
package prefix_sum_stage_pkg;
  localparam int INPUTSIZE_DEF = 32;
  localparam int GROUPSIZE_DEF = 4;
  localparam int GP_P = 0;
  localparam int GP_G = 1;
  localparam int RES_NEG = 0;
  localparam int RES_ZERO = 1;
  localparam int RES_OVF = 2;
  localparam int RES_COUT = 3;
  localparam int RES_SUM = 4;
  localparam int RES_FLAGS = 4;
  function automatic bit is_pow2(int v);
    return v > 0 && (v & (v - 1)) == 0;
  endfunction
endpackage

// File: rtl/prefix_sum_stage_ripple.sv
// group_sum_ripple: ripple-carry sum of one prefix group.
//   p_i/g_i  : per-bit propagate/generate of the group
//   c_i      : carry into the group (from the prefix tree)
//   sum_o    : sum slice
//   cout_o   : carry out of the group MSB
//   cmsb_o   : carry into the group MSB (for overflow detection)
module group_sum_ripple
  import prefix_sum_stage_pkg::*;
#(
  parameter int W = GROUPSIZE_DEF
) (
  input  logic [W-1:0] p_i,
  input  logic [W-1:0] g_i,
  input  logic         c_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o,
  output logic         cmsb_o
);
  logic [W:0] w_c;
  assign w_c[0] = c_i;
  for (genvar j = 0; j < W; j++) begin : g_bit
    assign w_c[j+1] = g_i[j] | (p_i[j] & w_c[j]);
  end
  assign sum_o  = p_i ^ w_c[W-1:0];
  assign cout_o = w_c[W];
  assign cmsb_o = w_c[W-1];
endmodule

// File: rtl/prefix_sum_stage.sv
// prefix_sum_stage: group carries + per-bit sum + ALU flags, buffered in a 2-entry FIFO.
//   clk/rst              : clock, synchronous active-high reset
//   in_valid/in_ready    : upstream handshake
//   p_i/g_i              : per-bit propagate/generate
//   gp_i                 : tree prefix pairs, pair k covers groups [k:0]
//   cin_i                : adder carry-in
//   out_valid/out_ready  : downstream handshake
//   sum_o/cout_o/ovf_o/zero_o/neg_o : result of the entry at the read pointer
module prefix_sum_stage
  import prefix_sum_stage_pkg::*;
#(
  parameter int INPUTSIZE = INPUTSIZE_DEF,
  parameter int GROUPSIZE = GROUPSIZE_DEF,
  parameter int TREESIZE  = INPUTSIZE / GROUPSIZE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INPUTSIZE-1:0]  p_i,
  input  logic [INPUTSIZE-1:0]  g_i,
  input  logic [TREESIZE*2-1:0] gp_i,
  input  logic                  cin_i,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INPUTSIZE-1:0]  sum_o,
  output logic                  cout_o,
  output logic                  ovf_o,
  output logic                  zero_o,
  output logic                  neg_o
);
  localparam int RES_W = INPUTSIZE + RES_FLAGS;
  if (INPUTSIZE % GROUPSIZE != 0 || !is_pow2(TREESIZE) || TREESIZE < 4
      || TREESIZE * GROUPSIZE != INPUTSIZE) begin : g_bad_cfg
    $error("prefix_sum_stage: invalid INPUTSIZE/GROUPSIZE/TREESIZE");
  end
  logic [TREESIZE-1:0]  w_gc;
  logic [TREESIZE-1:0]  w_gco;
  logic [TREESIZE-1:0]  w_gcm;
  logic [INPUTSIZE-1:0] w_sum;
  logic                 w_cout;
  logic                 w_ovf;
  logic [RES_W-1:0]     w_res;
  logic [RES_W-1:0]     w_head;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_unused;
  logic [RES_W-1:0]     r_mem [2];
  logic                 r_wp;
  logic                 r_rp;
  logic [1:0]           r_cnt;
  // Prefix pair k already resolves the carry out of groups [k:0] given cin.
  assign w_gc[0] = cin_i;
  for (genvar k = 1; k < TREESIZE; k++) begin : g_gc
    assign w_gc[k] = gp_i[2*(k-1)+GP_G] | (gp_i[2*(k-1)+GP_P] & cin_i);
  end
  for (genvar k = 0; k < TREESIZE; k++) begin : g_grp
    group_sum_ripple #(.W(GROUPSIZE)) u_grp (
      .p_i    (p_i[k*GROUPSIZE +: GROUPSIZE]),
      .g_i    (g_i[k*GROUPSIZE +: GROUPSIZE]),
      .c_i    (w_gc[k]),
      .sum_o  (w_sum[k*GROUPSIZE +: GROUPSIZE]),
      .cout_o (w_gco[k]),
      .cmsb_o (w_gcm[k])
    );
  end
  // Only the top group's ripple carries leave the datapath; the rest and the
  // full-width tree pair are superseded by the tree carries.
  assign w_unused = ^{w_gco[TREESIZE-2:0], w_gcm[TREESIZE-2:0], gp_i[2*TREESIZE-1 -: 2]};
  assign w_cout = w_gco[TREESIZE-1];
  assign w_ovf  = w_gco[TREESIZE-1] ^ w_gcm[TREESIZE-1];
  assign w_res  = {w_sum, w_cout, w_ovf, ~|w_sum, w_sum[INPUTSIZE-1]};
  assign in_ready  = r_cnt != 2'd2;
  assign out_valid = r_cnt != 2'd0;
  assign w_push = in_valid & in_ready;
  assign w_pop  = out_valid & out_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_mem[0] <= '0;
      r_mem[1] <= '0;
    end else begin
      if (w_push) r_mem[r_wp] <= w_res;
      r_wp  <= r_wp ^ w_push;
      r_rp  <= r_rp ^ w_pop;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end
  assign w_head = out_valid ? r_mem[r_rp] : '0;
  assign sum_o  = w_head[RES_SUM +: INPUTSIZE];
  assign cout_o = w_head[RES_COUT];
  assign ovf_o  = w_head[RES_OVF];
  assign zero_o = w_head[RES_ZERO];
  assign neg_o  = w_head[RES_NEG];
endmodule

// File: tb/tb_prefix_sum_stage.sv
// tb_prefix_sum_stage: directed + random checks of prefix_sum_stage against an arithmetic model.
module tb_prefix_sum_stage;
  logic        clk = 0;
  logic        rst = 1;
  logic        in_valid = 0;
  logic        in_ready;
  logic [31:0] p_i = 0;
  logic [31:0] g_i = 0;
  logic [15:0] gp_i = 0;
  logic        cin_i = 0;
  logic        out_valid;
  logic        out_ready = 0;
  logic [31:0] sum_o;
  logic        cout_o, ovf_o, zero_o, neg_o;
  int          ncmp = 0;
  int          nfail = 0;
  logic [35:0] q[$];
  logic [35:0] cur_exp;

  prefix_sum_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .p_i(p_i), .g_i(g_i), .gp_i(gp_i), .cin_i(cin_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum_o(sum_o), .cout_o(cout_o), .ovf_o(ovf_o), .zero_o(zero_o), .neg_o(neg_o)
  );

  always #5 clk = ~clk;

  function automatic logic [35:0] ref_res(logic [31:0] a, logic [31:0] b, logic ci);
    logic [32:0] s;
    logic        ov;
    s  = {1'b0, a} + {1'b0, b} + {32'd0, ci};
    ov = (a[31] == b[31]) && (s[31] != a[31]);
    return {s[31:0], s[32], ov, s[31:0] == 32'd0, s[31]};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(logic [31:0] a, logic [31:0] b, logic ci, logic v);
    logic [63:0] m;
    logic [63:0] s;
    p_i   = a ^ b;
    g_i   = a & b;
    cin_i = ci;
    for (int k = 0; k < 8; k++) begin
      m = (64'd1 << (4 * (k + 1))) - 64'd1;
      s = ({32'd0, a} & m) + ({32'd0, b} & m);
      gp_i[2*k+1] = s[4*(k+1)];
      gp_i[2*k]   = &((a ^ b) | ~m[31:0]);
    end
    cur_exp  = ref_res(a, b, ci);
    in_valid = v;
  endtask

  task automatic cycle();
    bit push, pop;
    logic [35:0] e;
    push = in_valid && q.size() != 2;
    pop  = out_ready && q.size() != 0;
    @(posedge clk);
    if (rst) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(cur_exp);
    end
    #1;
    e = q.size() != 0 ? q[0] : 36'd0;
    chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() != 0});
    chk("in_ready", {63'd0, in_ready}, {63'd0, q.size() != 2});
    chk("sum", {32'd0, sum_o}, {32'd0, e[35:4]});
    chk("flags", {60'd0, cout_o, ovf_o, zero_o, neg_o}, {60'd0, e[3:0]});
  endtask

  initial begin
    logic [31:0] ra, rb;
    rst = 1;
    cycle();
    rst = 0;
    chk("reset_sum", {32'd0, sum_o}, 64'd0);
    // carry out and zero
    out_ready = 1;
    drive(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1);
    cycle();
    chk("t1_sum", {32'd0, sum_o}, 64'h0);
    chk("t1_flags", {60'd0, cout_o, ovf_o, zero_o, neg_o}, 64'b1010);
    // signed overflow
    drive(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1);
    cycle();
    chk("t2_sum", {32'd0, sum_o}, 64'h80000000);
    chk("t2_flags", {60'd0, cout_o, ovf_o, zero_o, neg_o}, 64'b0101);
    drive(32'h12345678, 32'h0FEDCBA8, 1'b1, 1'b1);
    cycle();
    chk("t2b_sum", {32'd0, sum_o}, 64'h22222221);
    chk("t2b_flags", {60'd0, cout_o, ovf_o, zero_o, neg_o}, 64'b0000);
    drive(0, 0, 0, 0);
    cycle();
    // backpressure: three sets, only two fit
    out_ready = 0;
    drive(32'h00000010, 32'h00000020, 1'b0, 1'b1);
    cycle();
    drive(32'hDEADBEEF, 32'h01010101, 1'b1, 1'b1);
    cycle();
    chk("t3_full", {63'd0, in_ready}, 64'd0);
    drive(32'h80000000, 32'h80000000, 1'b0, 1'b1);
    cycle();
    cycle();
    chk("t3_first", {32'd0, sum_o}, 64'h00000030);
    out_ready = 1;
    cycle();
    chk("t3_second", {32'd0, sum_o}, 64'hDFAEBFF1);
    chk("t3_ready", {63'd0, in_ready}, 64'd1);
    cycle();
    drive(0, 0, 0, 0);
    chk("t3_third", {32'd0, sum_o}, 64'h0);
    chk("t3_third_cout", {63'd0, cout_o}, 64'd1);
    cycle();
    cycle();
    // steady stream
    for (int i = 0; i < 16; i++) begin
      drive($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1);
      cycle();
      chk("stream_valid", {63'd0, out_valid}, 64'd1);
      chk("stream_ready", {63'd0, in_ready}, 64'd1);
    end
    drive(0, 0, 0, 0);
    cycle();
    // count 1 with simultaneous push and pop
    out_ready = 0;
    drive(32'h00000005, 32'h00000007, 1'b0, 1'b1);
    cycle();
    out_ready = 1;
    drive(32'hAAAA0000, 32'h00005555, 1'b0, 1'b1);
    cycle();
    chk("t5_valid", {63'd0, out_valid}, 64'd1);
    chk("t5_new", {32'd0, sum_o}, 64'hAAAA5555);
    drive(0, 0, 0, 0);
    cycle();
    // random handshake toggling
    for (int i = 0; i < 1000; i++) begin
      if (!(in_valid && q.size() == 2)) begin
        ra = $urandom;
        rb = $urandom;
        drive(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      out_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    in_valid = 0;
    out_ready = 1;
    for (int i = 0; i < 4; i++) cycle();
    // reset with a full buffer, in_valid held during reset
    out_ready = 0;
    drive(32'h11111111, 32'h22222222, 1'b0, 1'b1);
    cycle();
    cycle();
    chk("t6_full", {63'd0, in_ready}, 64'd0);
    rst = 1;
    drive(32'h33333333, 32'h44444444, 1'b0, 1'b1);
    cycle();
    rst = 0;
    in_valid = 0;
    chk("t6_valid", {63'd0, out_valid}, 64'd0);
    chk("t6_ready", {63'd0, in_ready}, 64'd1);
    chk("t6_sum", {32'd0, sum_o}, 64'd0);
    cycle();
    chk("t6_not_accepted", {63'd0, out_valid}, 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
